soc_run_supervisor: RTL and testbench

Parametrised run supervisor for the PicoRV32 SoC. It sequences DUT reset release after a power-on/button reset, watches the trap lines of one or more harts, and enforces a cycle timeout. After a configurable drain period it reports a pass/fail verdict. The block is instantiated beside `picorv32_soc_top` in simulation benches and on-board, where it drives the SoC reset and the LED status.

---
 rtl/soc_run_supervisor_pkg.sv | 24 ++
 rtl/soc_sup_delay_cnt.sv | 38 +++
 rtl/soc_run_supervisor.sv | 166 ++++++++++++++++
 tb/tb_soc_run_supervisor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_run_supervisor_pkg.sv
// Shared types for the run supervisor: FSM states, run status codes and a
// constant helper used to size the delay counters.
package soc_run_supervisor_pkg;

    localparam int SUP_STATUS_W = 2;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_RUN        = 2'd1,
        ST_DRAIN      = 2'd2,
        ST_DONE       = 2'd3
    } sup_state_e;

    typedef enum logic [SUP_STATUS_W-1:0] {
        RUNNING = 2'd0,
        TRAP    = 2'd1,
        TIMEOUT = 2'd2
    } sup_status_e;

    function automatic int sup_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/soc_sup_delay_cnt.sv
// Load/count counter with a terminal flag; stops counting once the terminal
// value is reached so the flag stays asserted until the next load or reset.
module soc_sup_delay_cnt #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_term_val,
    output logic         o_term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign o_term = (cnt_q == i_term_val);

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = '0;
        end else if (i_en && !o_term) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/soc_run_supervisor.sv
// Run supervisor: sequences SoC reset release, watches hart traps, enforces a
// RUN-cycle timeout and reports a verdict after a drain period.
// Optional simulation reporting/termination: SOC_RUN_SUPERVISOR_FINISH_EN.
module soc_run_supervisor
    import soc_run_supervisor_pkg::*;
#(
    parameter int NUM_HARTS      = 1,
    parameter int RESET_CYCLES   = 10,
    parameter int DRAIN_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int STOP_ON_ANY    = 1,
    parameter int CYCLE_W        = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_HARTS-1:0]    i_trap,
    output logic                    o_dut_rst_n,
    output logic                    o_done,
    output logic                    o_pass,
    output logic [SUP_STATUS_W-1:0] o_status,
    output logic [NUM_HARTS-1:0]    o_trap_mask,
    output logic [CYCLE_W-1:0]      o_cycle_count
);

    localparam int CNT_W = $clog2(sup_max(RESET_CYCLES, DRAIN_CYCLES)) + 1;
    localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LAST = (DRAIN_CYCLES > 0) ? CNT_W'(DRAIN_CYCLES - 1) : '0;
    localparam logic [CYCLE_W-1:0] TO_LAST    = CYCLE_W'(TIMEOUT_CYCLES - 1);

    // Only a hard 1 counts as a trap; X/Z on an unreset hart must not end the run.
    function automatic logic [NUM_HARTS-1:0] known_ones(input logic [NUM_HARTS-1:0] v);
        logic [NUM_HARTS-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            r[i] = (v[i] === 1'b1);
        end
        return r;
    endfunction

    sup_state_e           state_q, state_d;
    sup_status_e          status_q, status_d;
    logic [NUM_HARTS-1:0] mask_q, mask_d;
    logic [CYCLE_W-1:0]   count_q, count_d, count_inc_s;
    logic                 dut_rst_n_q, dut_rst_n_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [NUM_HARTS-1:0] trap_s;
    logic                 trap_end_s, timeout_s, hold_term_s, drain_term_s;
    sup_state_e           exit_state_s;

    soc_sup_delay_cnt #(.W(CNT_W)) u_hold_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (1'b0),
        .i_en       (state_q == ST_RESET_HOLD),
        .i_term_val (HOLD_LAST),
        .o_term     (hold_term_s)
    );

    soc_sup_delay_cnt #(.W(CNT_W)) u_drain_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (state_q == ST_RUN),
        .i_en       (state_q == ST_DRAIN),
        .i_term_val (DRAIN_LAST),
        .o_term     (drain_term_s)
    );

    assign trap_s       = known_ones(i_trap);
    assign trap_end_s   = (STOP_ON_ANY != 0) ? (|trap_s) : (&(mask_q | trap_s));
    assign timeout_s    = (TIMEOUT_CYCLES != 0) && (count_q == TO_LAST);
    assign count_inc_s  = (count_q == {CYCLE_W{1'b1}}) ? count_q : count_q + CYCLE_W'(1);
    assign exit_state_s = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;

    // Next-state and next-output logic; a trap beats a timeout in the same cycle.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        mask_d   = mask_q;
        count_d  = count_q;
        done_d   = done_q;
        pass_d   = pass_q;
        case (state_q)
            ST_RESET_HOLD: begin
                if (hold_term_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_RESET_HOLD;
                end
            end
            ST_RUN: begin
                mask_d = mask_q | trap_s;
                if (trap_end_s) begin
                    status_d = TRAP;
                    count_d  = count_inc_s;
                    state_d  = exit_state_s;
                end else if (timeout_s) begin
                    status_d = TIMEOUT;
                    state_d  = exit_state_s;
                end else begin
                    count_d  = count_inc_s;
                end
            end
            ST_DRAIN: begin
                if (drain_term_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
                pass_d = (status_q == TRAP);
            end
            default: begin
                state_d = ST_RESET_HOLD;
            end
        endcase
        dut_rst_n_d = (state_d != ST_RESET_HOLD);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_RESET_HOLD;
            status_q    <= RUNNING;
            mask_q      <= '0;
            count_q     <= '0;
            dut_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            mask_q      <= mask_d;
            count_q     <= count_d;
            dut_rst_n_q <= dut_rst_n_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign o_dut_rst_n   = dut_rst_n_q;
    assign o_done        = done_q;
    assign o_pass        = pass_q;
    assign o_status      = status_q;
    assign o_trap_mask   = mask_q;
    assign o_cycle_count = count_q;

`ifdef SOC_RUN_SUPERVISOR_FINISH_EN
    // Report once, on the first cycle spent in DONE, then end the simulation.
    always_ff @(posedge i_clk) begin
        if (!i_rst && (state_q == ST_DONE) && !done_q) begin
            $display("Run done: status=%0d mask=%h cycles=%0d", status_q, mask_q, count_q);
            if (status_q == TRAP) begin
                $finish;
            end else begin
                $fatal(1, "Run ended without a trap");
            end
        end
    end
`else
    // On-board build: the verdict is reported through the outputs only.
`endif

endmodule

// File: tb/tb_soc_run_supervisor.sv
// Self-checking bench: two supervisor configurations driven from a vector
// table through an expected-value queue, plus hand-written corner sequences.
module tb_soc_run_supervisor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_dut_rst_n, a_done, a_pass;
    logic [0:0]  a_trap, a_mask;
    logic [1:0]  a_status;
    logic [31:0] a_count;

    logic        b_rst, b_dut_rst_n, b_done, b_pass;
    logic [3:0]  b_trap, b_mask;
    logic [1:0]  b_status;
    logic [7:0]  b_count;

    soc_run_supervisor #(
        .NUM_HARTS(1), .RESET_CYCLES(10), .DRAIN_CYCLES(10),
        .TIMEOUT_CYCLES(100), .STOP_ON_ANY(1), .CYCLE_W(32)
    ) dut_a (
        .i_clk(clk), .i_rst(a_rst), .i_trap(a_trap),
        .o_dut_rst_n(a_dut_rst_n), .o_done(a_done), .o_pass(a_pass),
        .o_status(a_status), .o_trap_mask(a_mask), .o_cycle_count(a_count)
    );

    soc_run_supervisor #(
        .NUM_HARTS(4), .RESET_CYCLES(3), .DRAIN_CYCLES(0),
        .TIMEOUT_CYCLES(0), .STOP_ON_ANY(0), .CYCLE_W(8)
    ) dut_b (
        .i_clk(clk), .i_rst(b_rst), .i_trap(b_trap),
        .o_dut_rst_n(b_dut_rst_n), .o_done(b_done), .o_pass(b_pass),
        .o_status(b_status), .o_trap_mask(b_mask), .o_cycle_count(b_count)
    );

    typedef struct packed {
        logic        dut_rst_n;
        logic        done;
        logic        pass;
        logic [1:0]  status;
        logic [3:0]  mask;
        logic [31:0] count;
    } obs_t;

    typedef struct {
        int         sel;
        logic       rst;
        logic [3:0] trap;
        int         n;
        obs_t       exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    obs_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic obs_t mk(input logic r, input logic d, input logic p,
                                input logic [1:0] s, input logic [3:0] m, input logic [31:0] c);
        obs_t o;
        o.dut_rst_n = r;
        o.done      = d;
        o.pass      = p;
        o.status    = s;
        o.mask      = m;
        o.count     = c;
        return o;
    endfunction

    function automatic obs_t observe(input int sel);
        if (sel == 0) begin
            return {a_dut_rst_n, a_done, a_pass, a_status, 3'b000, a_mask, a_count};
        end else begin
            return {b_dut_rst_n, b_done, b_pass, b_status, b_mask, 24'd0, b_count};
        end
    endfunction

    task automatic add(input int sel, input logic rst, input logic [3:0] trap, input int n,
                       input string name, input obs_t e);
        vec_t v;
        v.sel  = sel;
        v.rst  = rst;
        v.trap = trap;
        v.n    = n;
        v.exp  = e;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got rst_n=%0b done=%0b pass=%0b status=%0d mask=%h count=%0d, expected rst_n=%0b done=%0b pass=%0b status=%0d mask=%h count=%0d",
                     name, got.dut_rst_n, got.done, got.pass, got.status, got.mask, got.count,
                     exp.dut_rst_n, exp.done, exp.pass, exp.status, exp.mask, exp.count);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    obs_t zero_o;
    obs_t e;
    int   rise;
    logic seen_done;

    initial begin
        a_rst  = 1'b1;
        b_rst  = 1'b1;
        a_trap = 1'b0;
        b_trap = 4'h0;
        zero_o = mk(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0);

        // Reset release edge position on the default reset length.
        repeat (3) tick();
        check("a_reset_state", observe(0), zero_o);
        a_rst = 1'b0;
        rise  = 0;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (a_dut_rst_n) begin
                rise = k;
                break;
            end
        end
        n_cmp++;
        if (rise != 10) begin
            n_bad++;
            $display("FAIL a_rise_edge: got edge %0d, expected edge 10", rise);
        end
        check("a_rise_outputs", observe(0), mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0));

        // Config A: 1 hart, stop on any, drain 10, timeout 100.
        add(0, 1'b1, 4'h0, 3,   "a_reset",        zero_o);
        add(0, 1'b0, 4'h0, 9,   "a_hold9",        zero_o);
        add(0, 1'b0, 4'h0, 1,   "a_release",      mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0));
        add(0, 1'b0, 4'h0, 50,  "a_run50",        mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd50));
        add(0, 1'b0, 4'h1, 1,   "a_trap",         mk(1'b1, 1'b0, 1'b0, 2'd1, 4'h1, 32'd51));
        add(0, 1'b0, 4'h0, 10,  "a_drain",        mk(1'b1, 1'b0, 1'b0, 2'd1, 4'h1, 32'd51));
        add(0, 1'b0, 4'h0, 1,   "a_done",         mk(1'b1, 1'b1, 1'b1, 2'd1, 4'h1, 32'd51));
        add(0, 1'b0, 4'h1, 5,   "a_done_hold",    mk(1'b1, 1'b1, 1'b1, 2'd1, 4'h1, 32'd51));
        add(0, 1'b1, 4'h0, 1,   "a_rst_done",     zero_o);
        add(0, 1'b0, 4'h0, 10,  "a_release2",     mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0));
        add(0, 1'b0, 4'h0, 99,  "a_cnt99",        mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd99));
        add(0, 1'b0, 4'h0, 1,   "a_timeout",      mk(1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 32'd99));
        add(0, 1'b0, 4'h0, 10,  "a_to_drain",     mk(1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 32'd99));
        add(0, 1'b0, 4'h0, 1,   "a_to_done",      mk(1'b1, 1'b1, 1'b0, 2'd2, 4'h0, 32'd99));
        add(0, 1'b1, 4'h0, 1,   "a_rst_to",       zero_o);
        add(0, 1'b0, 4'h0, 10,  "a_release3",     mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0));
        add(0, 1'b0, 4'h0, 99,  "a_cnt99b",       mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd99));
        add(0, 1'b0, 4'h1, 1,   "a_trap_vs_to",   mk(1'b1, 1'b0, 1'b0, 2'd1, 4'h1, 32'd100));
        add(0, 1'b0, 4'h0, 3,   "a_drain3",       mk(1'b1, 1'b0, 1'b0, 2'd1, 4'h1, 32'd100));
        add(0, 1'b1, 4'h0, 1,   "a_abort",        zero_o);
        add(0, 1'b0, 4'h0, 5,   "a_abort_hold",   zero_o);
        // Config B: 4 harts, all must trap, no drain, no timeout, 8-bit count.
        add(1, 1'b1, 4'h0, 2,   "b_reset",        zero_o);
        add(1, 1'b0, 4'h0, 2,   "b_hold2",        zero_o);
        add(1, 1'b0, 4'h0, 1,   "b_release",      mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0));
        add(1, 1'b0, 4'h0, 10,  "b_run10",        mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd10));
        add(1, 1'b0, 4'h1, 1,   "b_trap0",        mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h1, 32'd11));
        add(1, 1'b0, 4'h0, 9,   "b_run20",        mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h1, 32'd20));
        add(1, 1'b0, 4'h4, 1,   "b_trap2",        mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h5, 32'd21));
        add(1, 1'b0, 4'h0, 9,   "b_run30",        mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h5, 32'd30));
        add(1, 1'b0, 4'h2, 1,   "b_trap1",        mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h7, 32'd31));
        add(1, 1'b0, 4'h0, 9,   "b_still_run",    mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h7, 32'd40));
        add(1, 1'b0, 4'h8, 1,   "b_trap3",        mk(1'b1, 1'b0, 1'b0, 2'd1, 4'hF, 32'd41));
        add(1, 1'b0, 4'h0, 1,   "b_done_nodrain", mk(1'b1, 1'b1, 1'b1, 2'd1, 4'hF, 32'd41));
        add(1, 1'b1, 4'h0, 1,   "b_rst2",         zero_o);
        add(1, 1'b0, 4'h0, 3,   "b_release2",     mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd0));
        add(1, 1'b0, 4'h0, 255, "b_cnt255",       mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd255));
        add(1, 1'b0, 4'h0, 10,  "b_saturate",     mk(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 32'd255));
        add(1, 1'b0, 4'hF, 1,   "b_trap_all",     mk(1'b1, 1'b0, 1'b0, 2'd1, 4'hF, 32'd255));
        add(1, 1'b0, 4'h0, 1,   "b_done2",        mk(1'b1, 1'b1, 1'b1, 2'd1, 4'hF, 32'd255));

        foreach (vecs[i]) begin
            if (vecs[i].sel == 0) begin
                a_rst  = vecs[i].rst;
                a_trap = vecs[i].trap[0:0];
            end else begin
                b_rst  = vecs[i].rst;
                b_trap = vecs[i].trap;
            end
            sb.push_back(vecs[i].exp);
            repeat (vecs[i].n) tick();
            e = sb.pop_front();
            check(vecs[i].name, observe(vecs[i].sel), e);
        end

        // Abort during DRAIN: reset values on the next edge, and no done pulse afterwards.
        a_rst  = 1'b1;
        a_trap = 1'b0;
        tick();
        a_rst = 1'b0;
        repeat (15) tick();
        a_trap = 1'b1;
        tick();
        a_trap = 1'b0;
        check("abort_pre_drain", observe(0), mk(1'b1, 1'b0, 1'b0, 2'd1, 4'h1, 32'd6));
        repeat (4) tick();
        a_rst = 1'b1;
        tick();
        check("abort_edge", observe(0), zero_o);
        a_rst     = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (a_done) seen_done = 1'b1;
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: got done pulse=%0b, expected 0", seen_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
